// File: rtl/sid_mix_out.sv
// Stereo SID voice mixer feeding the external-DAC serializer: six envelope-weighted
// voices through one shared multiplier, master volume, clip, offset-binary output.
module sid_mix_out #(
    parameter int unsigned DIV = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [35:0] voices_l,
    input  logic [23:0] env_l,
    input  logic [35:0] voices_r,
    input  logic [23:0] env_r,
    input  logic [3:0]  volume,
    output logic [11:0] sample_out_1,
    output logic [11:0] sample_out_2,
    output logic        sample_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MIX   = 2'd1,
        ST_SCALE = 2'd2,
        ST_CLIP  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t             state_r;
    state_t             state_s;
    logic [15:0]        cnt_r;
    logic               tick_s;
    logic               snap_s;
    logic               mix_s;
    logic               load_s;
    logic [35:0]        voices_l_r;
    logic [23:0]        env_l_r;
    logic [35:0]        voices_r_r;
    logic [23:0]        env_r_r;
    logic [3:0]         volume_r;
    logic [2:0]         idx_r;
    logic [22:0]        acc_l_r;
    logic [22:0]        acc_r_r;
    logic [11:0]        voice_s;
    logic [7:0]         env_s;
    logic [20:0]        prod_s;
    logic [22:0]        prod_ext_s;
    logic [11:0]        out1_r;
    logic [11:0]        out2_r;
    logic               ready_r;

    // Floor-scale an accumulator by 1/256, apply volume/16, clip to 12 bits, offset binary.
    function automatic logic [11:0] scale_clip(input logic [22:0] acc, input logic [3:0] vol);
        logic signed [22:0] sh;
        logic        [26:0] prod;
        logic signed [26:0] sc;
        logic        [11:0] clipped;
        sh   = $signed(acc) >>> 8;
        prod = {{4{sh[22]}}, sh} * {23'd0, vol};
        sc   = $signed(prod) >>> 4;
        if (sc > 27'sd2047) begin
            clipped = 12'h7FF;
        end else if (sc < -27'sd2048) begin
            clipped = 12'h800;
        end else begin
            clipped = sc[11:0];
        end
        return clipped ^ 12'h800;
    endfunction

    assign tick_s = enable && (cnt_r == DIV_LAST);

    // Sample-rate divider, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (!enable || (cnt_r == DIV_LAST)) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; ticks outside IDLE are ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = tick_s ? ST_MIX : ST_IDLE;
            ST_MIX:   state_s = (idx_r == 3'd5) ? ST_SCALE : ST_MIX;
            ST_SCALE: state_s = ST_CLIP;
            ST_CLIP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM control decode.
    always_comb begin
        snap_s = 1'b0;
        mix_s  = 1'b0;
        load_s = 1'b0;
        case (state_r)
            ST_IDLE:  snap_s = tick_s;
            ST_MIX:   mix_s  = 1'b1;
            ST_SCALE: load_s = 1'b1;
            ST_CLIP:  load_s = 1'b0;
            default:  load_s = 1'b0;
        endcase
    end

    // Operand select for the shared multiplier: idx 0..2 left voices, 3..5 right voices.
    always_comb begin
        voice_s = 12'h000;
        env_s   = 8'h00;
        case (idx_r)
            3'd0: begin voice_s = voices_l_r[11:0];  env_s = env_l_r[7:0];   end
            3'd1: begin voice_s = voices_l_r[23:12]; env_s = env_l_r[15:8];  end
            3'd2: begin voice_s = voices_l_r[35:24]; env_s = env_l_r[23:16]; end
            3'd3: begin voice_s = voices_r_r[11:0];  env_s = env_r_r[7:0];   end
            3'd4: begin voice_s = voices_r_r[23:12]; env_s = env_r_r[15:8];  end
            3'd5: begin voice_s = voices_r_r[35:24]; env_s = env_r_r[23:16]; end
            default: begin voice_s = 12'h000; env_s = 8'h00; end
        endcase
    end

    // Two's-complement low bits are sign-agnostic, so an unsigned multiply of the extended operands suffices.
    assign prod_s     = {{9{voice_s[11]}}, voice_s} * {13'd0, env_s};
    assign prod_ext_s = {{2{prod_s[20]}}, prod_s};

    // Input snapshot and sequential mix accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            voices_l_r <= 36'd0;
            env_l_r    <= 24'd0;
            voices_r_r <= 36'd0;
            env_r_r    <= 24'd0;
            volume_r   <= 4'd0;
            idx_r      <= 3'd0;
            acc_l_r    <= 23'd0;
            acc_r_r    <= 23'd0;
        end else if (snap_s) begin
            voices_l_r <= voices_l;
            env_l_r    <= env_l;
            voices_r_r <= voices_r;
            env_r_r    <= env_r;
            volume_r   <= volume;
            idx_r      <= 3'd0;
            acc_l_r    <= 23'd0;
            acc_r_r    <= 23'd0;
        end else if (mix_s) begin
            idx_r <= idx_r + 3'd1;
            if (idx_r < 3'd3) begin
                acc_l_r <= acc_l_r + prod_ext_s;
            end else begin
                acc_r_r <= acc_r_r + prod_ext_s;
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Outputs load on the edge entering CLIP, so the pulse and new samples appear eight cycles after the tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out1_r  <= 12'h800;
            out2_r  <= 12'h800;
            ready_r <= 1'b0;
        end else begin
            ready_r <= load_s;
            if (load_s) begin
                out1_r <= scale_clip(acc_l_r, volume_r);
                out2_r <= scale_clip(acc_r_r, volume_r);
            end else begin
                out1_r <= out1_r;
                out2_r <= out2_r;
            end
        end
    end

    assign sample_out_1 = out1_r;
    assign sample_out_2 = out2_r;
    assign sample_ready = ready_r;

endmodule
